key_entry: RTL and testbench
============================

KEY_ENTRY -- requirements
Module: key_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_SCANS, default 4: consecutive identical full scans needed to accept a press or a release; legal range 2..15.
REQ-002 SHALL have port mclk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port scan_en  input  1  row-advance strobe; a high level for one mclk cycle advances the scan by one row.
REQ-005 SHALL have port key_col  input  4  keypad column sense, active-low; externally synchronised.
REQ-006 SHALL have port key_row  output  4  keypad row drive, active-low one-hot.
REQ-007 SHALL have port key_valid  output  1  one-cycle pulse marking an accepted key press.
REQ-008 SHALL have port key_code  output  4  code of the last accepted key, {row[1:0], col[1:0]}.
REQ-009 SHALL have port set_h  output  5  entered hour, 0..23.
REQ-010 SHALL have port set_m  output  6  entered minute, 0..59.
REQ-011 SHALL have port set_valid  output  1  one-cycle pulse: set_h/set_m updated by a completed entry.
REQ-012 SHALL have port entry_busy  output  1  high while the entry FSM is not IDLE.
REQ-013 SHALL have port entry_pos  output  2  digit awaited: 0=H tens, 1=H units, 2=M tens, 3=M units; 0 in IDLE.

Function
REQ-014 SHALL drive key_row = ~(4'b0001 << row_idx), row_idx 0..3, wrapping 3->0.
REQ-015 SHALL, on each mclk with scan_en=1, sample key_col for the current row_idx and then advance row_idx by 1.
REQ-016 SHALL treat the 4 samples for rows 0..3 as one full scan, completed by the scan_en that samples row 3.
REQ-017 SHALL give a full scan result of key {r,c} when exactly one key bit is low across the whole scan.
REQ-018 SHALL give a full scan result of NONE when zero keys are low, or when two or more keys are low (ghost rejection).
REQ-019 SHALL, at each scan completion, increment a stable counter (saturating at DEBOUNCE_SCANS) if the result equals the previous result, else reset the counter to 1.
REQ-020 SHALL accept a press when the counter reaches DEBOUNCE_SCANS with a key result while armed; it then pulses key_valid, loads key_code and disarms.
REQ-021 SHALL rearm only after DEBOUNCE_SCANS consecutive NONE scans; a held key, or a direct change to a different key without release, produces no second key_valid.
REQ-022 SHALL assert key_valid in the mclk cycle immediately after the completing scan_en edge.
REQ-023 SHALL implement entry FSM states IDLE, HT, HU, MT, MU, acting only on cycles where key_valid=1.
REQ-024 SHALL, in IDLE, move to HT on code 0xA and ignore all other codes.
REQ-025 SHALL, in any non-IDLE state, restart at HT on code 0xA and discard all digits entered so far.
REQ-026 SHALL, in any non-IDLE state, return to IDLE on code 0xB with no set_valid and set_h/set_m unchanged.
REQ-027 SHALL treat codes 0..9 as digits in the non-IDLE states and ignore codes 0xC..0xF there.
REQ-028 SHALL apply these digit limits: HT accepts 0..2; HU accepts 0..9 if the H tens digit < 2, else 0..3; MT accepts 0..5; MU accepts 0..9.
REQ-029 SHALL ignore an out-of-range digit, with the state unchanged.
REQ-030 SHALL, on an accepted MU digit, load set_h = 10*Ht+Hu and set_m = 10*Mt+Mu in binary, pulse set_valid one cycle after that key_valid, and go to IDLE.
REQ-031 SHALL hold set_h/set_m between completed entries.

Reset
REQ-032 SHALL, while rst is high, asynchronously force: row_idx=0 (key_row=4'b1110), key_valid=0, key_code=0, set_h=0, set_m=0, set_valid=0, FSM=IDLE, entry_busy=0, entry_pos=0, stable counter=0, previous result=NONE, armed=1.
REQ-033 SHALL, when rst asserts mid-scan or mid-entry, abandon the partial scan and the partial entry; the first full scan after release starts at row 0.

Verification
REQ-034 SHALL be covered by: key 0x5 held 6 scans, DEBOUNCE_SCANS=4 -> exactly one key_valid, key_code=0x5, one cycle after the 4th scan completes.
REQ-035 SHALL be covered by: keys A,1,9,4,5 each pressed and released -> set_h=19, set_m=45, one set_valid pulse, entry_busy=0.
REQ-036 SHALL be covered by: keys A,2,7,3,5,9 -> 7 ignored (entry_pos stays 1), result set_h=23, set_m=59.
REQ-037 SHALL be covered by: keys A,1,B -> IDLE, no set_valid, set_h/set_m keep prior values.
REQ-038 SHALL be covered by: keys 0x1 and 0x6 held together 8 scans -> no key_valid.
REQ-039 SHALL be covered by: rst pulse after A,1,2 -> all outputs at reset values; then A,0,0,0,0 -> set_h=0, set_m=0, set_valid pulse.

Source files
------------

// File: rtl/key_entry.sv
`default_nettype none
// ============================================================================
//  Module   : key_entry
//  Purpose  : 4x4 keypad scanner with ghost rejection, scan-count debounce,
//             and an HH:MM entry FSM (A = start, B = cancel, 0..9 = digits).
//  Revision : 1.0  initial release
// ============================================================================
module key_entry #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic       scan_en,
  input  logic [3:0] key_col,
  output logic [3:0] key_row,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [4:0] set_h,
  output logic [5:0] set_m,
  output logic       set_valid,
  output logic       entry_busy,
  output logic [1:0] entry_pos
);

  localparam logic [3:0] DB_TARGET = 4'(DEBOUNCE_SCANS);
  // Scan result: bit 4 = key present, bits 3:0 = {row, col}; all zero = NONE.
  localparam logic [4:0] RES_NONE  = 5'b0_0000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HT   = 3'd1,
    HU   = 3'd2,
    MT   = 3'd3,
    MU   = 3'd4
  } entry_state_t;

  logic [1:0]   row_idx;
  logic [1:0]   acc_hits;     // keys seen so far this scan, saturating at 2
  logic [3:0]   acc_key;      // location of the most recent key seen this scan
  logic [4:0]   prev_res;
  logic [3:0]   stable_cnt;
  logic         armed;

  logic [3:0]   col_low;
  logic [2:0]   row_hits;
  logic [1:0]   row_col;
  logic [2:0]   scan_sum;
  logic [3:0]   hit_key;
  logic [4:0]   scan_res;
  logic [3:0]   cnt_next;

  entry_state_t state, state_nxt;
  logic         in_range;
  logic         digit_ok;
  logic [1:0]   h_tens;
  logic [3:0]   h_units;
  logic [2:0]   m_tens;

  assign key_row = ~(4'b0001 << row_idx);

  // Fold the current row sample into the running scan; compute result and debounce count.
  always_comb begin
    col_low  = ~key_col;
    row_hits = 3'd0;
    row_col  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (col_low[i]) begin
        row_hits = row_hits + 3'd1;
        row_col  = 2'(i);
      end
    end
    // Row 0 starts a new scan, so earlier accumulation is ignored there.
    scan_sum = ((row_idx == 2'd0) ? 3'd0 : {1'b0, acc_hits}) + row_hits;
    hit_key  = (row_hits != 3'd0) ? {row_idx, row_col} : acc_key;
    scan_res = (scan_sum == 3'd1) ? {1'b1, hit_key} : RES_NONE;
    if (scan_res != prev_res)
      cnt_next = 4'd1;
    else if (stable_cnt >= DB_TARGET)
      cnt_next = DB_TARGET;
    else
      cnt_next = stable_cnt + 4'd1;
  end

  // Row scanning, debounce bookkeeping and press acceptance.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      row_idx    <= 2'd0;
      acc_hits   <= 2'd0;
      acc_key    <= 4'd0;
      prev_res   <= RES_NONE;
      stable_cnt <= 4'd0;
      armed      <= 1'b1;
      key_valid  <= 1'b0;
      key_code   <= 4'd0;
    end else begin
      key_valid <= 1'b0;
      if (scan_en) begin
        row_idx  <= row_idx + 2'd1;
        acc_hits <= (scan_sum >= 3'd2) ? 2'd2 : scan_sum[1:0];
        acc_key  <= hit_key;
        if (row_idx == 2'd3) begin
          prev_res   <= scan_res;
          stable_cnt <= cnt_next;
          if (cnt_next == DB_TARGET) begin
            if (scan_res[4] && armed) begin
              key_valid <= 1'b1;
              key_code  <= scan_res[3:0];
              armed     <= 1'b0;
            end else if (!scan_res[4]) begin
              armed <= 1'b1;
            end
          end
        end
      end
    end
  end

  // Entry FSM state register.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Entry FSM next state, digit range check and status outputs.
  always_comb begin
    state_nxt = state;
    digit_ok  = 1'b0;
    in_range  = 1'b0;
    case (state)
      HT:      in_range = (key_code <= 4'd2);
      HU:      in_range = (h_tens < 2'd2) ? (key_code <= 4'd9) : (key_code <= 4'd3);
      MT:      in_range = (key_code <= 4'd5);
      MU:      in_range = (key_code <= 4'd9);
      default: in_range = 1'b0;
    endcase
    if (key_valid) begin
      if (key_code == 4'hA) begin
        state_nxt = HT;
      end else if (state != IDLE) begin
        if (key_code == 4'hB) begin
          state_nxt = IDLE;
        end else if (in_range) begin
          digit_ok = 1'b1;
          case (state)
            HT:      state_nxt = HU;
            HU:      state_nxt = MT;
            MT:      state_nxt = MU;
            default: state_nxt = IDLE;
          endcase
        end
      end
    end
    entry_busy = (state != IDLE);
    case (state)
      HU:      entry_pos = 2'd1;
      MT:      entry_pos = 2'd2;
      MU:      entry_pos = 2'd3;
      default: entry_pos = 2'd0;
    endcase
  end

  // Digit capture and time load on the final accepted digit.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      h_tens    <= 2'd0;
      h_units   <= 4'd0;
      m_tens    <= 3'd0;
      set_h     <= 5'd0;
      set_m     <= 6'd0;
      set_valid <= 1'b0;
    end else begin
      set_valid <= 1'b0;
      if (digit_ok) begin
        case (state)
          HT: h_tens  <= key_code[1:0];
          HU: h_units <= key_code;
          MT: m_tens  <= key_code[2:0];
          MU: begin
            set_h     <= 5'd10 * {3'b000, h_tens} + {1'b0, h_units};
            set_m     <= 6'd10 * {3'b000, m_tens} + {2'b00, key_code};
            set_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_key_entry.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_entry
//  Purpose  : Self-checking bench for key_entry: keypad emulation, behavioural
//             reference model, per-cycle compare and directed scenarios.
//  Revision : 1.0  initial release
// ============================================================================
module tb_key_entry;

  localparam int D = 4;

  logic       mclk = 1'b0;
  logic       rst = 1'b0;
  logic       scan_en = 1'b0;
  logic [3:0] key_col;
  logic [3:0] key_row;
  logic       key_valid;
  logic [3:0] key_code;
  logic [4:0] set_h;
  logic [5:0] set_m;
  logic       set_valid;
  logic       entry_busy;
  logic [1:0] entry_pos;

  logic [15:0] pressed = '0;   // bit {row,col} set = that key is held

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;
  int kv_count = 0;
  int sv_count = 0;

  key_entry #(.DEBOUNCE_SCANS(D)) dut (
    .mclk(mclk), .rst(rst), .scan_en(scan_en), .key_col(key_col),
    .key_row(key_row), .key_valid(key_valid), .key_code(key_code),
    .set_h(set_h), .set_m(set_m), .set_valid(set_valid),
    .entry_busy(entry_busy), .entry_pos(entry_pos)
  );

  always #5 mclk = ~mclk;

  // Physical keypad: a held key pulls its column low while its row is driven.
  always_comb begin
    key_col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!key_row[r] && pressed[r*4+c]) key_col[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int scan_result(input logic [3:0] s0, input logic [3:0] s1,
                                     input logic [3:0] s2, input logic [3:0] s3);
    logic [15:0] all;
    int cnt, pos;
    all = {s3, s2, s1, s0};
    cnt = 0;
    pos = -1;
    for (int i = 0; i < 16; i++)
      if (all[i]) begin cnt++; pos = i; end
    return (cnt == 1) ? pos : -1;
  endfunction

  function automatic bit lim_ok(input int pos, input int c, input int d0);
    case (pos)
      0: return c <= 2;
      1: return (d0 < 2) ? (c <= 9) : (c <= 3);
      2: return c <= 5;
      default: return c <= 9;
    endcase
  endfunction

  function automatic logic [3:0] row_drive(input int r);
    logic [3:0] v;
    v = 4'b0001 << r;
    return ~v;
  endfunction

  int         m_row, m_run, m_last, m_kc, m_pos, m_h, m_m;
  logic       m_kv, m_sv, m_armed;
  logic [3:0] m_samp [4];
  int         m_d [4];
  int         w_res, w_run;

  always_comb begin
    w_res = scan_result(m_samp[0], m_samp[1], m_samp[2], ~key_col);
    w_run = (w_res == m_last) ? m_run + 1 : 1;
  end

  always @(posedge mclk or posedge rst) begin
    if (rst) begin
      m_row <= 0; m_run <= 0; m_last <= -1; m_armed <= 1'b1;
      m_kv <= 1'b0; m_kc <= 0; m_pos <= -1; m_h <= 0; m_m <= 0; m_sv <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_samp[i] <= '0;
        m_d[i]    <= 0;
      end
    end else begin
      m_kv <= 1'b0;
      m_sv <= 1'b0;
      if (scan_en) begin
        m_row <= (m_row + 1) % 4;
        m_samp[m_row] <= ~key_col;
        if (m_row == 3) begin
          m_last <= w_res;
          m_run  <= w_run;
          if (w_run >= D && w_res >= 0 && m_armed) begin
            m_kv <= 1'b1; m_kc <= w_res; m_armed <= 1'b0;
          end else if (w_run >= D && w_res < 0) begin
            m_armed <= 1'b1;
          end
        end
      end
      if (m_kv) begin
        if (m_kc == 10) begin
          m_pos <= 0;
        end else if (m_pos >= 0) begin
          if (m_kc == 11) begin
            m_pos <= -1;
          end else if (m_kc <= 9 && lim_ok(m_pos, m_kc, m_d[0])) begin
            m_d[m_pos] <= m_kc;
            if (m_pos == 3) begin
              m_h <= m_d[0] * 10 + m_d[1];
              m_m <= m_d[2] * 10 + m_kc;
              m_sv <= 1'b1;
              m_pos <= -1;
            end else begin
              m_pos <= m_pos + 1;
            end
          end
        end
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge mclk) begin
    if (chk_on) begin
      check("key_row",    key_row,    row_drive(m_row));
      check("key_valid",  key_valid,  m_kv);
      check("key_code",   key_code,   m_kc);
      check("set_h",      set_h,      m_h);
      check("set_m",      set_m,      m_m);
      check("set_valid",  set_valid,  m_sv);
      check("entry_busy", entry_busy, (m_pos >= 0));
      check("entry_pos",  entry_pos,  (m_pos < 0) ? 0 : m_pos);
    end
  end

  always @(posedge mclk) begin
    if (key_valid === 1'b1) kv_count <= kv_count + 1;
    if (set_valid === 1'b1) sv_count <= sv_count + 1;
  end

  // ---------------- stimulus ----------------
  task automatic scan_row();
    @(negedge mclk) scan_en = 1'b1;
    @(negedge mclk) scan_en = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge mclk);
  endtask

  task automatic scans(input int n);
    repeat (n * 4) scan_row();
  endtask

  task automatic press(input int code);
    pressed = 16'(1) << code;
    scans(D + 1);
    pressed = '0;
    scans(D + 1);
  endtask

  task automatic check_reset_values();
    check("rst_key_row",    key_row,    4'b1110);
    check("rst_key_valid",  key_valid,  0);
    check("rst_key_code",   key_code,   0);
    check("rst_set_h",      set_h,      0);
    check("rst_set_m",      set_m,      0);
    check("rst_set_valid",  set_valid,  0);
    check("rst_entry_busy", entry_busy, 0);
    check("rst_entry_pos",  entry_pos,  0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k0, s0, a, b, r;
    #1 rst = 1'b1;
    #1 chk_on = 1'b1;
    check_reset_values();
    repeat (3) @(negedge mclk);
    rst = 1'b0;

    // Single key held 6 scans: exactly one accept, right after the 4th scan.
    k0 = kv_count;
    pressed = 16'(1) << 5;
    scans(3);
    repeat (3) scan_row();
    @(negedge mclk) scan_en = 1'b1;
    @(negedge mclk) scan_en = 1'b0;
    check("kv_after_4th_scan", key_valid, 1);
    check("code_after_4th_scan", key_code, 5);
    scans(2);
    pressed = '0;
    scans(D + 1);
    check("kv_count_held_key", kv_count - k0, 1);

    // A 1 9 4 5 -> 19:45
    s0 = sv_count;
    press(10); press(1); press(9); press(4); press(5);
    check("e1_set_h", set_h, 19);
    check("e1_set_m", set_m, 45);
    check("e1_sv_count", sv_count - s0, 1);
    check("e1_busy", entry_busy, 0);

    // A 2 7 3 5 9 -> 7 rejected, 23:59
    press(10); press(2); press(7);
    check("e2_pos_after_7", entry_pos, 1);
    press(3); press(5); press(9);
    check("e2_set_h", set_h, 23);
    check("e2_set_m", set_m, 59);

    // A 1 B -> cancelled, time unchanged
    s0 = sv_count;
    press(10); press(1); press(11);
    check("e3_busy", entry_busy, 0);
    check("e3_set_h", set_h, 23);
    check("e3_set_m", set_m, 59);
    check("e3_sv_count", sv_count - s0, 0);

    // Two keys held together: ghost rejected
    k0 = kv_count;
    pressed = (16'(1) << 1) | (16'(1) << 6);
    scans(8);
    pressed = '0;
    scans(D + 1);
    check("ghost_kv_count", kv_count - k0, 0);

    // Reset mid-entry and mid-scan, then A 0 0 0 0
    press(10); press(1); press(2);
    pressed = 16'(1) << 3;
    scan_row(); scan_row();
    #2 rst = 1'b1;
    #1 check_reset_values();
    @(negedge mclk) rst = 1'b0;
    pressed = '0;
    s0 = sv_count;
    press(10); press(0); press(0); press(0); press(0);
    check("e4_set_h", set_h, 0);
    check("e4_set_m", set_m, 0);
    check("e4_sv_count", sv_count - s0, 1);
    check("e4_busy", entry_busy, 0);

    // Randomised presses, ghosts, and direct key changes checked by the model.
    repeat (40) begin
      r = $urandom_range(0, 9);
      a = $urandom_range(0, 15);
      b = (a + 1 + $urandom_range(0, 14)) % 16;
      if (r == 0) begin
        pressed = (16'(1) << a) | (16'(1) << b);
        scans($urandom_range(1, 6));
      end else if (r == 1) begin
        pressed = 16'(1) << a;
        scans($urandom_range(3, 6));
        pressed = 16'(1) << b;
        scans($urandom_range(3, 6));
      end else begin
        pressed = 16'(1) << ((r < 4) ? 10 : a);
        scans($urandom_range(1, 6));
      end
      pressed = '0;
      scans($urandom_range(1, 6));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
